// File: rtl/chitchat_rx.sv
// chitchat_rx: CHITCHAT link receiver, frame parser and link qualifier.
// Hunts K28.5 starts, checks CRC and header, publishes accepted frames.
package chitchat_pkg;
  localparam logic [3:0]  CC_PROTOCOL_CAT = 4'h1;
  localparam logic [3:0]  CC_PROTOCOL_VER = 4'h1;
  localparam logic [7:0]  CC_K28_5        = 8'hBC;
  localparam logic [15:0] CC_CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CC_CRC_POLY     = 16'h1021;

  typedef struct packed {
    logic [2:0]  gw_type;
    logic [2:0]  location;
    logic [31:0] rev_id;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [15:0] fc;
    logic [15:0] lb;
  } cc_frame_t;
endpackage

module crc16
  import chitchat_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] crc
);
  function automatic logic [15:0] step(
    input logic [15:0] c,
    input logic [15:0] w
  );
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      r = (r[15] ^ w[i]) ? ({r[14:0], 1'b0} ^ CC_CRC_POLY)
                         : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc <= CC_CRC_INIT;
    else if (en) crc <= step(clr ? CC_CRC_INIT : crc, d);
  end
endmodule

module chitchat_rx
  import chitchat_pkg::*;
#(
  parameter int         LINK_UP_CNT      = 3,
  parameter logic [2:0] RX_GATEWARE_TYPE = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] gtx_d,
  input  logic        gtx_k,
  output logic        link_up,
  output logic        rx_valid,
  output logic [2:0]  rx_gateware_type,
  output logic [2:0]  rx_location,
  output logic [31:0] rx_rev_id,
  output logic [31:0] rx_data0,
  output logic [31:0] rx_data1,
  output logic [15:0] rx_frame_counter,
  output logic [15:0] rx_loopback_frame_counter,
  output logic        rx_frame_drop,
  output logic [2:0]  ccrx_fault,
  output logic [15:0] ccrx_fault_cnt
);
  typedef enum logic {HUNT, RECEIVE} state_t;

  localparam logic [3:0] LUC = 4'(LINK_UP_CNT);

  state_t     state;
  logic [3:0] idx;
  logic [7:0] w0_hi;
  cc_frame_t  sh;
  cc_frame_t  rx_q;
  logic [3:0] good_cnt;
  logic       is_sow;
  logic       crc_en;
  logic [15:0] crc;
  logic [2:0] fault_d;
  logic       frm_ok;

  assign is_sow = gtx_k && (gtx_d[7:0] == CC_K28_5);
  assign crc_en = is_sow ||
                  (state == RECEIVE && !gtx_k &&
                   idx >= 4'd1 && idx <= 4'd9);

  crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (is_sow),
    .en    (crc_en),
    .d     (gtx_d),
    .crc   (crc)
  );

  // idx 0 in RECEIVE: W10 seen, next word must be a start word
  always_comb begin
    fault_d = 3'b000;
    frm_ok  = 1'b0;
    if (state == RECEIVE) begin
      if (idx == 4'd0) begin
        fault_d[0] = !is_sow;
      end else if (gtx_k) begin
        fault_d[0] = 1'b1;
      end else if (idx == 4'd10) begin
        fault_d[1] = (gtx_d != crc);
        fault_d[2] = (w0_hi != {CC_PROTOCOL_CAT, CC_PROTOCOL_VER}) ||
                     (sh.gw_type != RX_GATEWARE_TYPE);
        frm_ok = !fault_d[1] && !fault_d[2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= HUNT;
      idx            <= 4'd0;
      w0_hi          <= 8'd0;
      sh             <= '0;
      rx_q           <= '0;
      good_cnt       <= 4'd0;
      link_up        <= 1'b0;
      rx_valid       <= 1'b0;
      rx_frame_drop  <= 1'b0;
      ccrx_fault     <= 3'b000;
      ccrx_fault_cnt <= 16'd0;
    end else begin
      rx_valid      <= 1'b0;
      rx_frame_drop <= 1'b0;
      ccrx_fault    <= fault_d;

      if (is_sow) begin
        state <= RECEIVE;
        idx   <= 4'd1;
        w0_hi <= gtx_d[15:8];
      end else if (state == RECEIVE) begin
        if (gtx_k || idx == 4'd0) begin
          state <= HUNT;
          idx   <= 4'd0;
        end else if (idx == 4'd10) begin
          idx <= 4'd0;
        end else begin
          idx <= idx + 4'd1;
          unique case (idx)
            4'd1: begin
              sh.gw_type  <= gtx_d[15:13];
              sh.location <= gtx_d[12:10];
            end
            4'd2: sh.rev_id[31:16] <= gtx_d;
            4'd3: sh.rev_id[15:0]  <= gtx_d;
            4'd4: sh.data0[31:16]  <= gtx_d;
            4'd5: sh.data0[15:0]   <= gtx_d;
            4'd6: sh.data1[31:16]  <= gtx_d;
            4'd7: sh.data1[15:0]   <= gtx_d;
            4'd8: sh.fc            <= gtx_d;
            4'd9: sh.lb            <= gtx_d;
            default: ;
          endcase
        end
      end

      if (|fault_d) begin
        good_cnt <= 4'd0;
        link_up  <= 1'b0;
        if (ccrx_fault_cnt != 16'hFFFF)
          ccrx_fault_cnt <= ccrx_fault_cnt + 16'd1;
      end else if (frm_ok) begin
        if (good_cnt < LUC) good_cnt <= good_cnt + 4'd1;
        // drop check skipped on the frame that first raises link_up
        if (link_up || (good_cnt + 4'd1 == LUC)) begin
          link_up       <= 1'b1;
          rx_valid      <= 1'b1;
          rx_q          <= sh;
          rx_frame_drop <= link_up && (sh.fc != rx_q.fc + 16'd1);
        end
      end
    end
  end

  assign rx_gateware_type          = rx_q.gw_type;
  assign rx_location               = rx_q.location;
  assign rx_rev_id                 = rx_q.rev_id;
  assign rx_data0                  = rx_q.data0;
  assign rx_data1                  = rx_q.data1;
  assign rx_frame_counter          = rx_q.fc;
  assign rx_loopback_frame_counter = rx_q.lb;
endmodule

// File: tb/tb_chitchat_rx.sv
// tb_chitchat_rx: random and directed frame streams against a frame-level
// reference model; expected events are queued and popped by a monitor.
module tb_chitchat_rx;
  import chitchat_pkg::*;

  localparam int         LUC = 3;
  localparam logic [2:0] GW  = 3'd3;

  localparam int K_GOOD  = 0;
  localparam int K_CRC   = 1;
  localparam int K_HDR   = 2;
  localparam int K_TRUNC = 3;
  localparam int K_CUT   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gtx_d;
  logic        gtx_k;
  logic        link_up;
  logic        rx_valid;
  logic [2:0]  rx_gateware_type;
  logic [2:0]  rx_location;
  logic [31:0] rx_rev_id;
  logic [31:0] rx_data0;
  logic [31:0] rx_data1;
  logic [15:0] rx_frame_counter;
  logic [15:0] rx_loopback_frame_counter;
  logic        rx_frame_drop;
  logic [2:0]  ccrx_fault;
  logic [15:0] ccrx_fault_cnt;

  chitchat_rx #(
    .LINK_UP_CNT      (LUC),
    .RX_GATEWARE_TYPE (GW)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .gtx_d                     (gtx_d),
    .gtx_k                     (gtx_k),
    .link_up                   (link_up),
    .rx_valid                  (rx_valid),
    .rx_gateware_type          (rx_gateware_type),
    .rx_location               (rx_location),
    .rx_rev_id                 (rx_rev_id),
    .rx_data0                  (rx_data0),
    .rx_data1                  (rx_data1),
    .rx_frame_counter          (rx_frame_counter),
    .rx_loopback_frame_counter (rx_loopback_frame_counter),
    .rx_frame_drop             (rx_frame_drop),
    .ccrx_fault                (ccrx_fault),
    .ccrx_fault_cnt            (ccrx_fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  gw;
    logic [2:0]  loc;
    logic [31:0] rev;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [15:0] fc;
    logic [15:0] lb;
    logic        drop;
  } vexp_t;

  typedef struct {
    logic [2:0]  bits;
    logic [15:0] cnt;
  } fexp_t;

  vexp_t vq[$];
  fexp_t fq[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  int          m_good;
  bit          m_link;
  logic [15:0] m_last_fc;
  logic [15:0] m_fcnt;
  logic [15:0] fc_tx;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [159:0] msg);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 159; i >= 0; i--) begin
      fb = r[15] ^ msg[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic model_fault(input logic [2:0] bits);
    if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
    fq.push_back('{bits, m_fcnt});
    m_good = 0;
    m_link = 0;
  endtask

  task automatic model_frame(input int kind, input logic [2:0] gw,
                             input logic [2:0] loc, input logic [31:0] rev,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [15:0] fc, input logic [15:0] lb);
    bit crc_bad;
    bit proto_bad;
    bit accept;
    crc_bad   = (kind == K_CRC);
    proto_bad = (kind == K_HDR) || (gw != GW);
    if (kind == K_TRUNC) begin
      model_fault(3'b001);
    end else if (crc_bad || proto_bad) begin
      model_fault({proto_bad, crc_bad, 1'b0});
    end else begin
      accept = m_link || (m_good + 1 == LUC);
      if (m_good < LUC) m_good++;
      if (accept) begin
        vq.push_back('{gw, loc, rev, d0, d1, fc, lb,
                       m_link && (fc != 16'(m_last_fc + 16'd1))});
        m_last_fc = fc;
        m_link    = 1;
      end
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic k);
    gtx_d = d;
    gtx_k = k;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int kind, input int cut_n,
                            input logic [31:0] d0, input logic [15:0] fc,
                            input logic [2:0] gw);
    logic [15:0]  w[0:10];
    logic [159:0] msg;
    logic [2:0]   loc;
    logic [31:0]  rev;
    logic [31:0]  d1;
    logic [15:0]  lb;
    int           n;
    loc  = 3'($urandom);
    rev  = $urandom;
    d1   = $urandom;
    lb   = 16'($urandom);
    w[0] = {CC_PROTOCOL_CAT, CC_PROTOCOL_VER, 8'hBC};
    if (kind == K_HDR) w[0][15:8] = w[0][15:8] ^ 8'($urandom_range(1, 255));
    w[1] = {gw, loc, 10'b0};
    w[2] = rev[31:16];
    w[3] = rev[15:0];
    w[4] = d0[31:16];
    w[5] = d0[15:0];
    w[6] = d1[31:16];
    w[7] = d1[15:0];
    w[8] = fc;
    w[9] = lb;
    msg  = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8], w[9]};
    w[10] = crc_ref(msg) ^ ((kind == K_CRC) ? 16'h0001 : 16'h0000);
    if (kind != K_CUT) model_frame(kind, gw, loc, rev, d0, d1, fc, lb);
    n = (kind == K_TRUNC || kind == K_CUT) ? cut_n : 11;
    for (int i = 0; i < n; i++) send_word(w[i], i == 0);
    if (n == 11) chk("link_up_after_frame", 32'(link_up), 32'(m_link));
  endtask

  task automatic gf();
    send_frame(K_GOOD, 11, $urandom, fc_tx, GW);
    fc_tx = fc_tx + 16'd1;
  endtask

  task automatic stop_stream();
    model_fault(3'b001);
    for (int i = 0; i < 5; i++) send_word(16'($urandom), 1'b0);
    chk("valid_queue_drained", 32'(vq.size()), 32'd0);
    chk("fault_queue_drained", 32'(fq.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_link_up"}, 32'(link_up), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_frame_drop"}, 32'(rx_frame_drop), 32'd0);
    chk({tag, "_fault"}, 32'(ccrx_fault), 32'd0);
    chk({tag, "_fault_cnt"}, 32'(ccrx_fault_cnt), 32'd0);
    chk({tag, "_hdr"}, 32'({rx_gateware_type, rx_location}), 32'd0);
    chk({tag, "_rev_id"}, rx_rev_id, 32'd0);
    chk({tag, "_data0"}, rx_data0, 32'd0);
    chk({tag, "_data1"}, rx_data1, 32'd0);
    chk({tag, "_counters"},
        {rx_frame_counter, rx_loopback_frame_counter}, 32'd0);
  endtask

  always @(negedge clk) begin
    vexp_t e;
    fexp_t f;
    if (rst_n === 1'b1) begin
      if (rx_valid !== 1'b0) begin
        if (vq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_valid_unexpected: got %b required 0", rx_valid);
        end else begin
          e = vq.pop_front();
          chk("rx_gateware_type", 32'(rx_gateware_type), 32'(e.gw));
          chk("rx_location", 32'(rx_location), 32'(e.loc));
          chk("rx_rev_id", rx_rev_id, e.rev);
          chk("rx_data0", rx_data0, e.d0);
          chk("rx_data1", rx_data1, e.d1);
          chk("rx_frame_counter", 32'(rx_frame_counter), 32'(e.fc));
          chk("rx_loopback", 32'(rx_loopback_frame_counter), 32'(e.lb));
          chk("rx_frame_drop", 32'(rx_frame_drop), 32'(e.drop));
          chk("link_up_at_valid", 32'(link_up), 32'd1);
        end
      end else begin
        if (rx_frame_drop !== 1'b0) begin
          n_chk++;
          n_fail++;
          $display("FAIL drop_without_valid: got %b required 0",
                   rx_frame_drop);
        end
      end
      if (ccrx_fault !== 3'b000) begin
        if (fq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL fault_unexpected: got %b required 000", ccrx_fault);
        end else begin
          f = fq.pop_front();
          chk("ccrx_fault", 32'(ccrx_fault), 32'(f.bits));
          chk("ccrx_fault_cnt", 32'(ccrx_fault_cnt), 32'(f.cnt));
          chk("link_up_at_fault", 32'(link_up), 32'd0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_good    = 0;
    m_link    = 0;
    m_last_fc = 16'd0;
    m_fcnt    = 16'd0;
    fc_tx     = 16'd100;
    rst_n     = 1'b0;
    gtx_d     = 16'd0;
    gtx_k     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // four back-to-back good frames, counters 5..8
    for (int i = 0; i < 4; i++)
      send_frame(K_GOOD, 11, 32'hDEADBEEF, 16'(5 + i), GW);
    stop_stream();

    // corrupted CRC drops the link, three good frames restore it
    repeat (4) gf();
    send_frame(K_CRC, 11, $urandom, fc_tx, GW);
    fc_tx = fc_tx + 16'd1;
    repeat (4) gf();
    stop_stream();

    // start word injected at W5 restarts the frame
    repeat (4) gf();
    send_frame(K_TRUNC, 5, $urandom, fc_tx, GW);
    repeat (4) gf();
    stop_stream();

    // counter wrap is continuous, a jump to 5 is a drop
    fc_tx = 16'hFFFC;
    repeat (6) begin
      gf();
      if (fc_tx == 16'h0001) fc_tx = 16'h0005;
    end
    stop_stream();

    // protocol faults: bad W0 byte, then gateware type 1 against 3
    repeat (4) gf();
    send_frame(K_HDR, 11, $urandom, fc_tx, GW);
    repeat (4) gf();
    send_frame(K_GOOD, 11, $urandom, fc_tx, 3'd1);
    stop_stream();

    for (int i = 0; i < 60; i++) begin
      int         r;
      int         kind;
      logic [2:0] g;
      r    = $urandom_range(0, 99);
      kind = (r < 75) ? K_GOOD : (r < 85) ? K_CRC :
             (r < 90) ? K_HDR : K_TRUNC;
      g    = ($urandom_range(0, 99) < 90) ? GW : 3'($urandom);
      if ($urandom_range(0, 99) < 15) fc_tx = 16'($urandom);
      send_frame(kind, $urandom_range(1, 10), $urandom, fc_tx, g);
      fc_tx = fc_tx + 16'd1;
    end
    gf();
    stop_stream();

    // reset pulsed during W6 of a linked stream
    repeat (4) gf();
    send_frame(K_CUT, 6, $urandom, fc_tx, GW);
    gtx_d = 16'($urandom);
    gtx_k = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    m_good    = 0;
    m_link    = 0;
    m_last_fc = 16'd0;
    m_fcnt    = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) send_word(16'($urandom), 1'b0);
    chk("hunt_ignores_tail", 32'(link_up), 32'd0);
    repeat (3) gf();
    stop_stream();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
